div_mod_serial: RTL and testbench

DIV_MOD_SERIAL -- requirements
Module: div_mod_serial

---
 rtl/div_pkg.sv | 28 ++
 rtl/mod_step.sv | 32 +++
 rtl/div_mod_serial.sv | 131 +++++++++++++
 tb/tb_div_mod_serial.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the serial modulus checker:
//   state_t : FSM state encoding (IDLE, RUN)
//   clog2() : ceiling log2, used to size the remainder and length registers
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ceiling log2 evaluated at elaboration time. clog2(1) = 0, clog2(2) = 1,
    // clog2(3) = 2, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage : div_pkg

// File: rtl/mod_step.sv
// -----------------------------------------------------------------------------
// mod_step
// Combinational fold of one serial bit into a running remainder:
//   rem_next = (2*rem + bit_in) mod DIVISOR
//
// Ports:
//   rem      [RW-1:0] in   current remainder, always < DIVISOR
//   bit_in            in   next operand bit (MSB-first stream)
//   rem_next [RW-1:0] out  updated remainder, always < DIVISOR
// -----------------------------------------------------------------------------
module mod_step
    import div_pkg::*;
#(
    parameter  int DIVISOR = 3,
    localparam int RW      = clog2(DIVISOR)
) (
    input  logic [RW-1:0] rem,
    input  logic          bit_in,
    output logic [RW-1:0] rem_next
);

    // DIVISOR itself may equal 2**RW, so it needs RW+1 bits to be held exactly.
    localparam logic [RW:0] DIV_C = (RW + 1)'(DIVISOR);

    // Since rem < DIVISOR, the doubled value plus one bit is < 2*DIVISOR.
    // A single conditional subtraction therefore always lands in range.
    logic [RW:0] sum;

    assign sum      = {rem, bit_in};
    assign rem_next = (sum >= DIV_C) ? RW'(sum - DIV_C) : sum[RW-1:0];

endmodule : mod_step

// File: rtl/div_mod_serial.sv
// -----------------------------------------------------------------------------
// div_mod_serial
// Serial (MSB-first) divisibility checker. Each consumed bit updates a running
// remainder modulo DIVISOR; a word is delimited by start/finish strobes and its
// completion is flagged with a one-cycle out_valid pulse.
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst             in   synchronous active-high reset
//   in_data         in   serial operand bit
//   in_data_start   in   first bit of a word (restarts a word in progress)
//   in_data_finish  in   last bit of a word
//   out_remainder   out  [RW-1:0] registered running remainder
//   out_is_div      out  remainder is zero
//   out_valid       out  one-cycle pulse after the finishing bit is consumed
//   out_busy        out  word in progress
//   out_len         out  [CW-1:0] bits consumed, saturating at MAX_BITS
//   out_overflow    out  sticky: word ran past MAX_BITS bits
// -----------------------------------------------------------------------------
module div_mod_serial
    import div_pkg::*;
#(
    parameter  int DIVISOR  = 3,
    parameter  int MAX_BITS = 32,
    localparam int RW       = clog2(DIVISOR),
    localparam int CW       = clog2(MAX_BITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_data,
    input  logic          in_data_start,
    input  logic          in_data_finish,
    output logic [RW-1:0] out_remainder,
    output logic          out_is_div,
    output logic          out_valid,
    output logic          out_busy,
    output logic [CW-1:0] out_len,
    output logic          out_overflow
);

    localparam logic [CW-1:0] MAX_LEN = CW'(MAX_BITS);

    state_t        state_reg, state_next;
    logic [RW-1:0] rem_reg,   rem_next;
    logic [CW-1:0] len_reg,   len_next;
    logic          ovf_reg,   ovf_next;
    logic          valid_reg, valid_next;

    logic          consume;
    logic [RW-1:0] step_rem;
    logic [RW-1:0] step_out;

    // A bit is consumed on every RUN cycle and on any start strobe, whether
    // that start opens a fresh word from IDLE or restarts one in RUN.
    assign consume  = (state_reg == RUN) || in_data_start;

    // Starting a word folds the bit into a zero remainder, which yields
    // in_data mod DIVISOR without a separate path for the first bit.
    assign step_rem = in_data_start ? '0 : rem_reg;

    mod_step #(
        .DIVISOR (DIVISOR)
    ) u_mod_step (
        .rem      (step_rem),
        .bit_in   (in_data),
        .rem_next (step_out)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            len_reg   <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            len_reg   <= len_next;
            ovf_reg   <= ovf_next;
            valid_reg <= valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        len_next   = len_reg;
        ovf_next   = ovf_reg;
        valid_next = 1'b0;

        if (consume) begin
            state_next = in_data_finish ? IDLE : RUN;
            valid_next = in_data_finish;
        end

        if (in_data_start) begin
            // New word (possibly discarding one in progress).
            rem_next = step_out;
            len_next = CW'(1);
            ovf_next = 1'b0;
        end else if (state_reg == RUN) begin
            rem_next = step_out;
            // Length saturates; the remainder keeps tracking exactly.
            if (len_reg == MAX_LEN) begin
                ovf_next = 1'b1;
            end else begin
                len_next = len_reg + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        out_remainder = rem_reg;
        out_is_div    = (rem_reg == '0);
        out_valid     = valid_reg;
        out_busy      = (state_reg == RUN);
        out_len       = len_reg;
        out_overflow  = ovf_reg;
    end

endmodule : div_mod_serial

// File: tb/tb_div_mod_serial.sv
// -----------------------------------------------------------------------------
// tb_div_mod_serial
// Three instances (DIVISOR/MAX_BITS = 3/32, 5/32, 7/4) share one input stream.
// A behavioural model tracks each instance; every completed word pushes its
// expected result to a per-instance queue, popped when out_valid is seen.
// -----------------------------------------------------------------------------
module tb_div_mod_serial;

    logic clk = 1'b0;
    logic rst;
    logic in_data;
    logic in_data_start;
    logic in_data_finish;

    logic [1:0] r3; logic d3, v3, b3, o3; logic [5:0] l3;
    logic [2:0] r5; logic d5, v5, b5, o5; logic [5:0] l5;
    logic [2:0] r7; logic d7, v7, b7, o7; logic [2:0] l7;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int rem;
        int len;
        bit ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int divs [3] = '{3, 5, 7};
    int maxb [3] = '{32, 32, 4};
    int m_rem[3];
    int m_len[3];
    bit m_ovf[3];
    bit m_busy[3];
    bit m_valid[3];

    always #5 clk = ~clk;

    div_mod_serial #(.DIVISOR(3), .MAX_BITS(32)) u3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_data_start(in_data_start),
        .in_data_finish(in_data_finish), .out_remainder(r3), .out_is_div(d3),
        .out_valid(v3), .out_busy(b3), .out_len(l3), .out_overflow(o3)
    );

    div_mod_serial #(.DIVISOR(5), .MAX_BITS(32)) u5 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_data_start(in_data_start),
        .in_data_finish(in_data_finish), .out_remainder(r5), .out_is_div(d5),
        .out_valid(v5), .out_busy(b5), .out_len(l5), .out_overflow(o5)
    );

    div_mod_serial #(.DIVISOR(7), .MAX_BITS(4)) u7 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_data_start(in_data_start),
        .in_data_finish(in_data_finish), .out_remainder(r7), .out_is_div(d7),
        .out_valid(v7), .out_busy(b7), .out_len(l7), .out_overflow(o7)
    );

    // ------------------------------------------------------------------
    // Stimulus and model
    // ------------------------------------------------------------------
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rem[i]   = 0;
            m_len[i]   = 0;
            m_ovf[i]   = 1'b0;
            m_busy[i]  = 1'b0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic clear_queues();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Drive one cycle of inputs, advance the model across the rising edge,
    // then leave the caller 1 time unit after the edge to sample outputs.
    task automatic drive(input bit s, input bit f, input bit d);
        exp_t e;
        @(negedge clk);
        rst            = 1'b0;
        in_data_start  = s;
        in_data_finish = f;
        in_data        = d;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            bit cons;
            cons       = m_busy[i] || s;
            m_valid[i] = cons && f;
            if (s) begin
                m_rem[i] = int'(d) % divs[i];
                m_len[i] = 1;
                m_ovf[i] = 1'b0;
            end else if (m_busy[i]) begin
                m_rem[i] = (2 * m_rem[i] + int'(d)) % divs[i];
                if (m_len[i] == maxb[i]) m_ovf[i] = 1'b1;
                else                     m_len[i] = m_len[i] + 1;
            end
            if (cons) begin
                m_busy[i] = !f;
                if (f) begin
                    e.rem = m_rem[i];
                    e.len = m_len[i];
                    e.ovf = m_ovf[i];
                    case (i)
                        0:       q0.push_back(e);
                        1:       q1.push_back(e);
                        default: q2.push_back(e);
                    endcase
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst            = 1'b1;
        in_data_start  = 1'b0;
        in_data_finish = 1'b0;
        in_data        = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        apply_reset();
        checks++; if (r3 !== 2'd0) begin errors++; $display("FAIL reset_rem got %0d want 0", r3); end
        checks++; if (d3 !== 1'b1) begin errors++; $display("FAIL reset_is_div got %0b want 1", d3); end
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", v3); end
        checks++; if (b3 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", b3); end
        checks++; if (l3 !== 6'd0) begin errors++; $display("FAIL reset_len got %0d want 0", l3); end
        checks++; if (o3 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", o3); end
        checks++; if (r7 !== 3'd0 || l7 !== 3'd0) begin errors++; $display("FAIL reset_u7 got rem %0d len %0d want 0 0", r7, l7); end
        // finish alone in IDLE must be ignored
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (v3 !== 1'b0 || b3 !== 1'b0 || r3 !== 2'd0) begin
            errors++; $display("FAIL idle_finish got valid %0b busy %0b rem %0d want 0 0 0", v3, b3, r3);
        end
        $display("test_reset done");
    endtask

    task automatic test_div3_six();
        bit s_t[3] = '{1'b1, 1'b0, 1'b0};
        bit f_t[3] = '{1'b0, 1'b0, 1'b1};
        bit d_t[3] = '{1'b1, 1'b1, 1'b0};
        int r_t[3] = '{1, 0, 0};
        exp_t e;
        clear_queues();
        for (int k = 0; k < 3; k++) begin
            drive(s_t[k], f_t[k], d_t[k]);
            checks++; if (r3 !== r_t[k]) begin errors++; $display("FAIL div3_rem[%0d] got %0d want %0d", k, r3, r_t[k]); end
            if (k < 2) begin
                checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL div3_early_valid[%0d] got %0b want 0", k, v3); end
            end
        end
        checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL div3_valid got %0b want 1", v3); end
        checks++; if (d3 !== 1'b1) begin errors++; $display("FAIL div3_is_div got %0b want 1", d3); end
        checks++; if (l3 !== 6'd3) begin errors++; $display("FAIL div3_len got %0d want 3", l3); end
        checks++;
        if (q0.size() == 0) begin
            errors++; $display("FAIL div3_sb got empty queue want one entry");
        end else begin
            e = q0.pop_front();
            if (r3 !== e.rem || l3 !== e.len || o3 !== e.ovf) begin
                errors++; $display("FAIL div3_sb got rem %0d len %0d ovf %0b want %0d %0d %0b", r3, l3, o3, e.rem, e.len, e.ovf);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (v3 !== 1'b0 || b3 !== 1'b0) begin errors++; $display("FAIL div3_pulse_end got valid %0b busy %0b want 0 0", v3, b3); end
        $display("test_div3_six done");
    endtask

    task automatic test_div5_eleven();
        bit s_t[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        bit f_t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit d_t[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int r_t[4] = '{1, 2, 0, 1};
        int vcount = 0;
        exp_t e;
        clear_queues();
        for (int k = 0; k < 4; k++) begin
            drive(s_t[k], f_t[k], d_t[k]);
            if (v5 === 1'b1) vcount++;
            checks++; if (r5 !== r_t[k]) begin errors++; $display("FAIL div5_rem[%0d] got %0d want %0d", k, r5, r_t[k]); end
        end
        checks++; if (d5 !== 1'b0) begin errors++; $display("FAIL div5_is_div got %0b want 0", d5); end
        checks++;
        if (q1.size() == 0 || v5 !== 1'b1) begin
            errors++; $display("FAIL div5_sb got valid %0b queue %0d want 1 1", v5, q1.size());
        end else begin
            e = q1.pop_front();
            if (r5 !== e.rem || l5 !== e.len) begin
                errors++; $display("FAIL div5_sb got rem %0d len %0d want %0d %0d", r5, l5, e.rem, e.len);
            end
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b0);
            if (v5 === 1'b1) vcount++;
        end
        checks++; if (vcount != 1) begin errors++; $display("FAIL div5_pulses got %0d want 1", vcount); end
        $display("test_div5_eleven done");
    endtask

    task automatic test_single_bit();
        exp_t e;
        clear_queues();
        drive(1'b1, 1'b1, 1'b1);
        checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", v3); end
        checks++; if (r3 !== 2'd1) begin errors++; $display("FAIL single_rem got %0d want 1", r3); end
        checks++; if (l3 !== 6'd1) begin errors++; $display("FAIL single_len got %0d want 1", l3); end
        checks++; if (d3 !== 1'b0 || b3 !== 1'b0) begin errors++; $display("FAIL single_flags got is_div %0b busy %0b want 0 0", d3, b3); end
        checks++;
        if (q0.size() != 1) begin
            errors++; $display("FAIL single_sb got queue %0d want 1", q0.size());
        end else begin
            e = q0.pop_front();
            if (r3 !== e.rem || l3 !== e.len) begin
                errors++; $display("FAIL single_sb got rem %0d len %0d want %0d %0d", r3, l3, e.rem, e.len);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %0b want 0", v3); end
        $display("test_single_bit done");
    endtask

    task automatic test_restart();
        bit s_t[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bit f_t[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit d_t[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int vcount = 0;
        exp_t e;
        clear_queues();
        for (int k = 0; k < 5; k++) begin
            drive(s_t[k], f_t[k], d_t[k]);
            if (k < 4 && v3 === 1'b1) vcount++;
        end
        checks++; if (vcount != 0) begin errors++; $display("FAIL restart_spurious_valid got %0d want 0", vcount); end
        checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL restart_valid got %0b want 1", v3); end
        checks++; if (r3 !== 2'd1) begin errors++; $display("FAIL restart_rem got %0d want 1", r3); end
        checks++; if (l3 !== 6'd3) begin errors++; $display("FAIL restart_len got %0d want 3", l3); end
        checks++;
        if (q0.size() != 1) begin
            errors++; $display("FAIL restart_sb got queue %0d want 1", q0.size());
        end else begin
            e = q0.pop_front();
            if (r3 !== e.rem || l3 !== e.len) begin
                errors++; $display("FAIL restart_sb got rem %0d len %0d want %0d %0d", r3, l3, e.rem, e.len);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        $display("test_restart done");
    endtask

    task automatic test_overflow();
        exp_t e;
        clear_queues();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (l7 !== 3'd4 || o7 !== 1'b0) begin errors++; $display("FAIL ovf_at_max got len %0d ovf %0b want 4 0", l7, o7); end
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (o7 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", o7); end
        checks++; if (l7 !== 3'd4) begin errors++; $display("FAIL ovf_len got %0d want 4", l7); end
        checks++; if (r7 !== 3'd3) begin errors++; $display("FAIL ovf_rem got %0d want 3", r7); end
        checks++;
        if (q2.size() != 1 || v7 !== 1'b1) begin
            errors++; $display("FAIL ovf_sb got valid %0b queue %0d want 1 1", v7, q2.size());
        end else begin
            e = q2.pop_front();
            if (r7 !== e.rem || l7 !== e.len || o7 !== e.ovf) begin
                errors++; $display("FAIL ovf_sb got rem %0d len %0d ovf %0b want %0d %0d %0b", r7, l7, o7, e.rem, e.len, e.ovf);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (o7 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", o7); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (o7 !== 1'b0 || l7 !== 3'd1 || b7 !== 1'b1) begin
            errors++; $display("FAIL ovf_clear got ovf %0b len %0d busy %0b want 0 1 1", o7, l7, b7);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid_word();
        exp_t e;
        int vcount = 0;
        clear_queues();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        apply_reset();
        if (v3 === 1'b1) vcount++;
        checks++; if (r3 !== 2'd0 || d3 !== 1'b1 || b3 !== 1'b0 || l3 !== 6'd0 || o3 !== 1'b0) begin
            errors++; $display("FAIL midrst_state got rem %0d is_div %0b busy %0b len %0d ovf %0b want 0 1 0 0 0", r3, d3, b3, l3, o3);
        end
        drive(1'b1, 1'b0, 1'b1);
        if (v3 === 1'b1) vcount++;
        drive(1'b0, 1'b0, 1'b0);
        if (v3 === 1'b1) vcount++;
        checks++; if (vcount != 0) begin errors++; $display("FAIL midrst_valid got %0d want 0", vcount); end
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (v3 !== 1'b1 || r3 !== 2'd2 || l3 !== 6'd3) begin
            errors++; $display("FAIL midrst_next got valid %0b rem %0d len %0d want 1 2 3", v3, r3, l3);
        end
        checks++;
        if (q0.size() != 1) begin
            errors++; $display("FAIL midrst_sb got queue %0d want 1", q0.size());
        end else begin
            e = q0.pop_front();
            if (r3 !== e.rem || l3 !== e.len) begin
                errors++; $display("FAIL midrst_sb got rem %0d len %0d want %0d %0d", r3, l3, e.rem, e.len);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        $display("test_reset_mid_word done");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        clear_queues();
        for (int w = 0; w < 12; w++) begin
            n = $urandom_range(1, 7);
            for (int k = 0; k < n; k++) begin
                drive(k == 0, k == n - 1, 1'($urandom_range(0, 1)));
                checks++;
                if (r5 !== m_rem[1] || l5 !== m_len[1] || b5 !== m_busy[1] || v5 !== m_valid[1]) begin
                    errors++; $display("FAIL b2b_u5 w%0d b%0d got rem %0d len %0d busy %0b valid %0b want %0d %0d %0b %0b",
                                       w, k, r5, l5, b5, v5, m_rem[1], m_len[1], m_busy[1], m_valid[1]);
                end
                checks++;
                if (r7 !== m_rem[2] || l7 !== m_len[2] || o7 !== m_ovf[2]) begin
                    errors++; $display("FAIL b2b_u7 w%0d b%0d got rem %0d len %0d ovf %0b want %0d %0d %0b",
                                       w, k, r7, l7, o7, m_rem[2], m_len[2], m_ovf[2]);
                end
                if (v5 === 1'b1) begin
                    checks++;
                    if (q1.size() == 0) begin
                        errors++; $display("FAIL b2b_sb w%0d got unexpected valid want empty", w);
                    end else begin
                        e = q1.pop_front();
                        if (r5 !== e.rem || l5 !== e.len || d5 !== (e.rem == 0)) begin
                            errors++; $display("FAIL b2b_sb w%0d got rem %0d len %0d is_div %0b want %0d %0d", w, r5, l5, d5, e.rem, e.len);
                        end
                    end
                end
            end
            $display("b2b word %0d len %0d rem5 %0d rem7 %0d", w, n, r5, r7);
        end
        checks++; if (q1.size() != 0) begin errors++; $display("FAIL b2b_leftover got %0d want 0", q1.size()); end
        drive(1'b0, 1'b0, 1'b0);
        $display("test_back_to_back done");
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        rst            = 1'b1;
        in_data        = 1'b0;
        in_data_start  = 1'b0;
        in_data_finish = 1'b0;
        model_reset();
        test_reset();
        test_div3_six();
        test_div5_eleven();
        test_single_bit();
        test_restart();
        test_overflow();
        test_reset_mid_word();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_div_mod_serial
